sram_rw_port_ctrl: RTL

//  Request/response front end for port 0 (RW) of the 32x256 OpenRAM macro.

---
 rtl/sram_rw_port_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/sram_rw_port_ctrl.sv
// Valid/ready front end for the RW port (port 0) of the 32x256 OpenRAM macro.
// Define SRAM_CTRL_CLEAR_EN to zero-fill the whole array after every reset.
module sram_rw_port_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_WMASKS = 4,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [NUM_WMASKS-1:0] req_wmask,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0
);
    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_CLEAR,
        ST_RUN
    } state_e;

`ifdef SRAM_CTRL_CLEAR_EN
    localparam state_e RESET_STATE = ST_CLEAR;
`else
    localparam state_e RESET_STATE = ST_BOOT;
`endif

    state_e                state_q, state_d;
    logic                  init_done_q, init_done_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic                  csb_q, csb_d;
    logic                  web_q, web_d;
    logic [NUM_WMASKS-1:0] wmask_q, wmask_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic                  rd1_q, rd1_d;
    logic                  rd2_q, rd2_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] fifo_mem_q [RSP_DEPTH];

    logic                  accept;
    logic                  push;
    logic                  pop;
    logic [CNT_W:0]        occupancy;

    // Reads in flight already own a FIFO slot, so the FIFO can never overflow.
    assign occupancy = {1'b0, cnt_q}
                     + (CNT_W+1)'(rd1_q)
                     + (CNT_W+1)'(rd2_q);

    assign req_ready = init_done_q
                     & (occupancy < (CNT_W+1)'(RSP_DEPTH));
    assign accept    = req_valid & req_ready;
    assign push      = rd2_q;
    assign rsp_valid = (cnt_q != '0);
    assign pop       = rsp_valid & rsp_ready;
    assign rsp_rdata = fifo_mem_q[rd_ptr_q];

    assign init_done   = init_done_q;
    assign sram_csb0   = csb_q;
    assign sram_web0   = web_q;
    assign sram_wmask0 = wmask_q;
    assign sram_addr0  = addr_q;
    assign sram_din0   = din_q;

    always_comb begin
        state_d     = state_q;
        init_done_d = init_done_q;
        clr_cnt_d   = clr_cnt_q;
        csb_d       = 1'b1;
        web_d       = 1'b1;
        wmask_d     = wmask_q;
        addr_d      = addr_q;
        din_d       = din_q;
        rd1_d       = 1'b0;
        rd2_d       = rd1_q;
        wr_ptr_d    = wr_ptr_q + PTR_W'(push);
        rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
        cnt_d       = cnt_q + CNT_W'(push) - CNT_W'(pop);

        unique case (state_q)
            ST_BOOT: begin
                state_d     = ST_RUN;
                init_done_d = 1'b1;
            end
            ST_CLEAR: begin
                csb_d     = 1'b0;
                web_d     = 1'b0;
                wmask_d   = '1;
                din_d     = '0;
                addr_d    = clr_cnt_q;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == '1) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    csb_d   = 1'b0;
                    web_d   = ~req_we;
                    wmask_d = req_wmask;
                    addr_d  = req_addr;
                    din_d   = req_wdata;
                    rd1_d   = ~req_we;
                end
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RESET_STATE;
            init_done_q <= 1'b0;
            clr_cnt_q   <= '0;
            csb_q       <= 1'b1;
            web_q       <= 1'b1;
            wmask_q     <= '0;
            addr_q      <= '0;
            din_q       <= '0;
            rd1_q       <= 1'b0;
            rd2_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            init_done_q <= init_done_d;
            clr_cnt_q   <= clr_cnt_d;
            csb_q       <= csb_d;
            web_q       <= web_d;
            wmask_q     <= wmask_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            rd1_q       <= rd1_d;
            rd2_q       <= rd2_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
        end
    end

    // dout0 is only meaningful in the cycle the stage-2 tag is set.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= sram_dout0;
        end
    end

    property p_no_overflow;
        @(posedge clk) disable iff (reset)
            !(push && !pop && (cnt_q == CNT_W'(RSP_DEPTH)));
    endproperty
    assert property (p_no_overflow);

endmodule
